// File: rtl/chess_pkg.sv
// Shared types for the timed chess game: FSM states, player encoding, piece codes
// and square-index helpers (idx = y*8 + x).
package chess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_COMMIT,
        ST_SWITCH,
        ST_OVER
    } state_t;

    localparam logic WHITE_PLAYER = 1'b1;
    localparam logic BLACK_PLAYER = 1'b0;

    typedef enum logic [2:0] {
        PIECE_NONE = 3'd0,
        PAWN       = 3'd1,
        KNIGHT     = 3'd2,
        BISHOP     = 3'd3,
        ROOK       = 3'd4,
        QUEEN      = 3'd5,
        KING       = 3'd6
    } piece_t;

    function automatic logic [5:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

    function automatic logic [2:0] sq_x(input logic [5:0] idx);
        return idx[2:0];
    endfunction

    function automatic logic [2:0] sq_y(input logic [5:0] idx);
        return idx[5:3];
    endfunction

endpackage

// File: rtl/chess_player_clock.sv
// One player's countdown clock: reload, saturating decrement at zero and
// saturating increment at all-ones.
module chess_player_clock #(
    parameter int unsigned TIME_WIDTH = 10,
    parameter int unsigned INIT_TIME  = 300,
    parameter int unsigned INCREMENT  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  dec_en,
    input  logic                  inc_en,
    output logic [TIME_WIDTH-1:0] secs,
    output logic                  zero
);

    localparam logic [TIME_WIDTH-1:0] INIT_VAL = TIME_WIDTH'(INIT_TIME);
    localparam logic [TIME_WIDTH:0]   INC_VAL  = (TIME_WIDTH + 1)'(INCREMENT);

    logic [TIME_WIDTH:0] sum;

    assign sum  = {1'b0, secs} + INC_VAL;
    assign zero = (secs == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secs <= INIT_VAL;
        end else if (load) begin
            secs <= INIT_VAL;
        end else if (dec_en) begin
            if (!zero) secs <= secs - 1'b1;
        end else if (inc_en) begin
            secs <= sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/chess_turn_scheduler.sv
// Turn/time scheduler: FSM, move request registers and two player clocks.
// Optional build macro CHESS_INCREMENT_EN adds INCREMENT seconds to the mover per commit.
module chess_turn_scheduler
    import chess_pkg::*;
#(
    parameter int unsigned TIME_WIDTH = 10,
    parameter int unsigned INIT_TIME  = 300,
    parameter int unsigned INCREMENT  = 2,
    parameter int unsigned IDX_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  resetApp,
    input  logic                  TickSec,
    input  logic                  StartGame,
    input  logic                  MoveReq,
    input  logic [IDX_WIDTH-1:0]  MoveSrc,
    input  logic [IDX_WIDTH-1:0]  MoveDst,
    input  logic                  MoveValid,
    output logic                  MoveAck,
    output logic                  MoveReject,
    output logic                  LayoutWrEn,
    output logic [IDX_WIDTH-1:0]  LayoutSrcIdx,
    output logic [IDX_WIDTH-1:0]  LayoutDstIdx,
    output logic                  ActivePlayer,
    output logic [TIME_WIDTH-1:0] WhiteTime,
    output logic [TIME_WIDTH-1:0] BlackTime,
    output logic                  GameOver,
    output logic                  Winner
);

    state_t state, next_state;

    logic                  load, dec_en, capture;
    logic                  white_zero, black_zero;
    logic                  white_inc, black_inc;
    logic [TIME_WIDTH-1:0] active_secs;
    logic                  active_last;

    assign active_secs = ActivePlayer ? WhiteTime : BlackTime;
    assign active_last = (ActivePlayer ? white_zero : black_zero) ||
                         (active_secs == TIME_WIDTH'(1));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        dec_en     = 1'b0;
        capture    = 1'b0;
        MoveAck    = 1'b0;
        MoveReject = 1'b0;
        LayoutWrEn = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (StartGame) begin
                    load       = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dec_en = TickSec;
                if (TickSec && active_last) begin
                    next_state = ST_OVER;
                end else if (MoveReq) begin
                    capture    = 1'b1;
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                dec_en = TickSec;
                if (TickSec && active_last) begin
                    next_state = ST_OVER;
                end else if (MoveValid) begin
                    next_state = ST_COMMIT;
                end else begin
                    MoveReject = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_COMMIT: begin
                LayoutWrEn = 1'b1;
                MoveAck    = 1'b1;
                next_state = ST_SWITCH;
            end
            ST_SWITCH: next_state = ST_WAIT;
            ST_OVER: begin
                if (StartGame) begin
                    load       = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign GameOver = (state == ST_OVER);

`ifdef CHESS_INCREMENT_EN
    assign white_inc = (state == ST_COMMIT) &&  ActivePlayer;
    assign black_inc = (state == ST_COMMIT) && !ActivePlayer;
`else
    assign white_inc = 1'b0;
    assign black_inc = 1'b0;
`endif

    // The player flips on the COMMIT->SWITCH edge so the new mover is visible
    // during SWITCH, three cycles after the request.
    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            state        <= ST_IDLE;
            ActivePlayer <= WHITE_PLAYER;
            Winner       <= 1'b0;
            LayoutSrcIdx <= '0;
            LayoutDstIdx <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                ActivePlayer <= WHITE_PLAYER;
            end else if (state == ST_COMMIT) begin
                ActivePlayer <= ~ActivePlayer;
            end
            if (state != ST_OVER && next_state == ST_OVER) Winner <= ~ActivePlayer;
            if (capture) begin
                LayoutSrcIdx <= MoveSrc;
                LayoutDstIdx <= MoveDst;
            end
        end
    end

    chess_player_clock #(
        .TIME_WIDTH (TIME_WIDTH),
        .INIT_TIME  (INIT_TIME),
        .INCREMENT  (INCREMENT)
    ) u_white_clock (
        .clk    (clock),
        .rst_n  (resetApp),
        .load   (load),
        .dec_en (dec_en && ActivePlayer),
        .inc_en (white_inc),
        .secs   (WhiteTime),
        .zero   (white_zero)
    );

    chess_player_clock #(
        .TIME_WIDTH (TIME_WIDTH),
        .INIT_TIME  (INIT_TIME),
        .INCREMENT  (INCREMENT)
    ) u_black_clock (
        .clk    (clock),
        .rst_n  (resetApp),
        .load   (load),
        .dec_en (dec_en && !ActivePlayer),
        .inc_en (black_inc),
        .secs   (BlackTime),
        .zero   (black_zero)
    );

endmodule
